// File: rtl/drop_timer_pkg.sv
// Shared widths, default periods and FSM state type for the gravity drop timer.
package drop_timer_pkg;
  localparam int SPEED_W = 64;
  localparam int DCNT_W  = 16;

  localparam logic [SPEED_W-1:0] SOFT_PERIOD_DEF = 64'd1000000;
  localparam logic [SPEED_W-1:0] MIN_PERIOD_DEF  = 64'd1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_ACK
  } drop_state_t;
endpackage

// File: rtl/drop_period_sel.sv
// Effective gravity period: soft-drop picks the shorter of the two periods, then clamp to MIN_PERIOD.
// Purely combinational, so a level change or soft_drop edge takes effect on the same cycle.
module drop_period_sel
  import drop_timer_pkg::*;
#(
  parameter logic [SPEED_W-1:0] SOFT_PERIOD = SOFT_PERIOD_DEF,
  parameter logic [SPEED_W-1:0] MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic [SPEED_W-1:0] move_speed,
  input  logic               soft_drop,
  output logic [SPEED_W-1:0] period
);
  logic [SPEED_W-1:0] sel;

  always_comb begin
    sel = move_speed;
    if (soft_drop && (SOFT_PERIOD < move_speed)) sel = SOFT_PERIOD;
    period = (sel < MIN_PERIOD) ? MIN_PERIOD : sel;
  end
endmodule

// File: rtl/drop_timer.sv
// Gravity timer: raises drop_req once per effective period and holds it until drop_ack.
// Optional sticky missed-period flag `overrun` is built only when DROP_TIMER_OVERRUN_EN is defined.
module drop_timer
  import drop_timer_pkg::*;
#(
  parameter logic [SPEED_W-1:0] SOFT_PERIOD = SOFT_PERIOD_DEF,
  parameter logic [SPEED_W-1:0] MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] move_speed,
  input  logic               enable,
  input  logic               pause,
  input  logic               soft_drop,
  input  logic               restart,
  input  logic               drop_ack,
  output logic               drop_req,
`ifdef DROP_TIMER_OVERRUN_EN
  output logic               overrun,
`endif
  output logic [DCNT_W-1:0]  drop_count
);
  drop_state_t        state, state_n;
  logic [SPEED_W-1:0] count, count_n;
  logic [DCNT_W-1:0]  dcnt_n;
  logic [SPEED_W-1:0] period;
  logic               terminal;
`ifdef DROP_TIMER_OVERRUN_EN
  logic               ovr_n;
`endif

  drop_period_sel #(
    .SOFT_PERIOD (SOFT_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period (
    .move_speed (move_speed),
    .soft_drop  (soft_drop),
    .period     (period)
  );

  // 65-bit compare so an all-ones count cannot wrap past the terminal test.
  assign terminal = ({1'b0, count} + 65'd1) >= {1'b0, period};
  assign drop_req = (state == WAIT_ACK);

  always_comb begin
    state_n = state;
    count_n = count;
    dcnt_n  = drop_count;
`ifdef DROP_TIMER_OVERRUN_EN
    ovr_n   = overrun;
`endif
    if (restart) begin
      state_n = enable ? RUN : IDLE;
      count_n = '0;
`ifdef DROP_TIMER_OVERRUN_EN
      ovr_n   = 1'b0;
`endif
    end else if (!enable) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: state_n = RUN;
        RUN: begin
          if (!pause) begin
            if (terminal) begin
              count_n = '0;
              state_n = WAIT_ACK;
            end else begin
              count_n = count + 64'd1;
            end
          end
        end
        WAIT_ACK: begin
          // Saturating at P-1 makes the deferred drop fire on the first RUN cycle after the ack.
          if (!pause) begin
            if (terminal) begin
              count_n = period - 64'd1;
`ifdef DROP_TIMER_OVERRUN_EN
              ovr_n   = 1'b1;
`endif
            end else begin
              count_n = count + 64'd1;
            end
          end
          if (drop_ack) begin
            state_n = RUN;
            dcnt_n  = drop_count + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      drop_count <= '0;
`ifdef DROP_TIMER_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      drop_count <= dcnt_n;
`ifdef DROP_TIMER_OVERRUN_EN
      overrun    <= ovr_n;
`endif
    end
  end
endmodule
